param_counter: RTL and testbench

PARAM_COUNTER -- requirements
Module: param_counter

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_prescaler.sv | 55 +++++
 rtl/param_counter.sv | 141 ++++++++++++++
 tb/tb_param_counter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the parameterised counter: mode encodings and the
// one-shot FSM state type.
package counter_pkg;

    // Values of the 2-bit mode input. The fourth encoding is reserved and
    // behaves like MODE_FREE.
    localparam logic [1:0] MODE_FREE    = 2'd0;
    localparam logic [1:0] MODE_SAT     = 2'd1;
    localparam logic [1:0] MODE_ONESHOT = 2'd2;

    // One-shot sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage : counter_pkg

// File: rtl/counter_prescaler.sv
// Step divider for param_counter. When PARAM_COUNTER_PRESCALE_EN is defined,
// tick rises once every div+1 enabled cycles. The phase freezes while en is
// low, and clr restarts the phase. When the macro is undefined, tick is a
// constant 1 and no flops are built.
module counter_prescaler #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

`ifdef PARAM_COUNTER_PRESCALE_EN
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    // The >= compare stops a div that shrinks mid-count from letting the
    // phase run all the way round before the next tick.
    assign tick = (cnt_q >= div);

    // Next phase: clear, advance or wrap on enabled cycles, and hold otherwise.
    always_comb begin
        // NOTE: assign every always_comb output a default first so that no
        // path leaves it unassigned, which would infer a latch.
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    // Phase register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only. Reset is
        // sampled on the clock edge (synchronous), so rst_n is not in the
        // sensitivity list.
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // No divider is built. The inputs are gathered into a sink so that the
    // port list stays the same for both builds.
    logic unused_inputs;
    assign unused_inputs = ^{clk, rst_n, en, clr, div};
    assign tick          = 1'b1;
`endif

endmodule : counter_prescaler

// File: rtl/param_counter.sv
// Up/down modulo counter with three modes: FREE (wrap), SAT (saturate with a
// sticky overflow flag) and ONESHOT (armed by start, runs once to the terminal
// value). Priority in each cycle: reset > load > start > step. A step is
// en & prescaler tick. Optional prescaler: define PARAM_COUNTER_PRESCALE_EN.
module param_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] MOD_MAX    = {WIDTH{1'b1}},
    parameter int unsigned      PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  dir,
    input  logic [1:0]            mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  clr_ovf,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  ovf
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    state_e           state_q, state_d;

    logic             tick;
    logic             step;
    logic             presc_clr;
    logic             ovf_set;
    logic             start_ok;
    logic             at_lim;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] up_next;
    logic [WIDTH-1:0] dn_next;
    logic [WIDTH-1:0] nxt;

    counter_prescaler #(
        .DIV_W (PRESCALE_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (presc_clr),
        .div   (prescale),
        .tick  (tick)
    );

    assign step = en & tick;

    // Neighbour values modulo MOD_MAX+1, and the limit in the current direction.
    assign up_next  = (count_q == MOD_MAX) ? '0 : count_q + 1'b1;
    assign dn_next  = (count_q == '0) ? MOD_MAX : count_q - 1'b1;
    assign nxt      = dir ? up_next : dn_next;
    assign term     = dir ? MOD_MAX : '0;
    assign at_lim   = (count_q == term);
    assign start_ok = start && (mode == MODE_ONESHOT) && (state_q != ST_RUN);

    // Next count, tc, FSM state and overflow, in priority order load > start > step.
    always_comb begin
        count_d   = count_q;
        tc_d      = 1'b0;
        state_d   = state_q;
        ovf_set   = 1'b0;
        presc_clr = 1'b0;

        if (load) begin
            count_d   = (load_val > MOD_MAX) ? MOD_MAX : load_val;
            presc_clr = 1'b1;
        end else if (start_ok) begin
            count_d = dir ? '0 : MOD_MAX;
            state_d = ST_RUN;
        end else if (step) begin
            case (mode)
                MODE_SAT: begin
                    if (at_lim) begin
                        ovf_set = 1'b1;
                    end else begin
                        count_d = nxt;
                        tc_d    = (nxt == term);
                    end
                end
                MODE_ONESHOT: begin
                    if (state_q == ST_RUN) begin
                        if (at_lim) begin
                            // A load left the count at the terminal value.
                            tc_d    = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            count_d = nxt;
                            if (nxt == term) begin
                                tc_d    = 1'b1;
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
                default: begin
                    // FREE and the reserved encoding: wrap, with tc on the wrap.
                    count_d = nxt;
                    tc_d    = at_lim;
                end
            endcase
        end

        // When the mode leaves ONESHOT, the FSM returns to IDLE and the count is kept.
        if (mode != MODE_ONESHOT) begin
            state_d = ST_IDLE;
        end

        // A set in the same cycle as clr_ovf wins.
        ovf_d = ovf_set | (ovf_q & ~clr_ovf);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            state_q <= ST_IDLE;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            state_q <= state_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign busy  = (state_q == ST_RUN);

endmodule : param_counter

// File: tb/tb_param_counter.sv
// Directed bench for param_counter with WIDTH=4 and MOD_MAX=9. The expected
// values are worked out by hand for each step.
module tb_param_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       dir;
    logic [1:0] mode;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       clr_ovf;
    logic [3:0] prescale;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       ovf;

    int errors = 0;
    int checks = 0;

    param_counter #(
        .WIDTH      (4),
        .MOD_MAX    (4'd9),
        .PRESCALE_W (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .clr_ovf  (clr_ovf),
        .prescale (prescale),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input int c, input bit t, input bit b, input bit o);
        check({tag, "/count"}, 32'(count), 32'(c));
        check({tag, "/tc"},    32'(tc),    32'(t));
        check({tag, "/busy"},  32'(busy),  32'(b));
        check({tag, "/ovf"},   32'(ovf),   32'(o));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; dir = 1'b1; mode = 2'd0; load = 1'b0;
        load_val = 4'd0; start = 1'b0; clr_ovf = 1'b0; prescale = 4'd0;

        // Reset state.
        tick(); tick();
        check_all("reset", 0, 0, 0, 0);

        // FREE mode, counting up: 1..9, 0, 1, 2, with tc only at the wrap.
        rst_n = 1'b1; en = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("free_up/count", 32'(count), 32'(i % 10));
            check("free_up/tc", 32'(tc), 32'((i % 10) == 0));
        end

        // Hold while en is low.
        en = 1'b0;
        tick();
        check_all("hold_en0", 2, 0, 0, 0);

        // FREE mode, counting down: from 0 wrap to 9 with tc, then 8.
        load = 1'b1; load_val = 4'd0;
        tick();
        check_all("load0", 0, 0, 0, 0);
        load = 1'b0; dir = 1'b0; en = 1'b1;
        tick();
        check_all("free_dn_wrap", 9, 1, 0, 0);
        tick();
        check_all("free_dn", 8, 0, 0, 0);

        // Load clamps to MOD_MAX, wins over a step and gives no tc.
        load = 1'b1; load_val = 4'd15;
        tick();
        check_all("load_clamp", 9, 0, 0, 0);

        // SAT mode, counting up from 7: 8, 9 (tc), 9 (ovf), 9.
        mode = 2'd1; load_val = 4'd7; dir = 1'b1;
        tick();
        check_all("sat_load7", 7, 0, 0, 0);
        load = 1'b0;
        tick(); check_all("sat_8", 8, 0, 0, 0);
        tick(); check_all("sat_9", 9, 1, 0, 0);
        tick(); check_all("sat_hold1", 9, 0, 0, 1);
        tick(); check_all("sat_hold2", 9, 0, 0, 1);
        // When set and clear occur together, ovf stays set.
        clr_ovf = 1'b1;
        tick(); check_all("ovf_set_clr", 9, 0, 0, 1);
        en = 1'b0;
        tick(); check_all("ovf_clr", 9, 0, 0, 0);
        clr_ovf = 1'b0;

        // SAT mode, counting down: from 1 to 0 with tc, then ovf at 0.
        load = 1'b1; load_val = 4'd1; dir = 1'b0;
        tick();
        load = 1'b0; en = 1'b1;
        tick(); check_all("sat_dn_0", 0, 1, 0, 0);
        tick(); check_all("sat_dn_ovf", 0, 0, 0, 1);
        clr_ovf = 1'b1; en = 1'b0;
        tick(); check("sat_dn_clr/ovf", 32'(ovf), 32'd0);
        clr_ovf = 1'b0;

        // Reserved mode 3 behaves like FREE.
        mode = 2'd3; load = 1'b1; load_val = 4'd9; dir = 1'b1;
        tick();
        load = 1'b0; en = 1'b1;
        tick(); check_all("mode3_wrap", 0, 1, 0, 0);

        // start is ignored outside ONESHOT.
        mode = 2'd0; load = 1'b1; load_val = 4'd5; en = 1'b0;
        tick();
        load = 1'b0; start = 1'b1;
        tick(); check_all("start_free", 5, 0, 0, 0);

        // ONESHOT counting up: start gives 0 and busy, then 1..9, with tc at 9.
        mode = 2'd2; en = 1'b1;
        tick(); check_all("os_start", 0, 0, 1, 0);
        start = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check("os_run/count", 32'(count), 32'(i));
            check("os_run/busy", 32'(busy), 32'(i < 9));
            check("os_run/tc", 32'(tc), 32'(i == 9));
        end
        tick(); check_all("os_done1", 9, 0, 0, 0);
        tick(); check_all("os_done2", 9, 0, 0, 0);

        // A second start restarts from 0. start during RUN is ignored.
        start = 1'b1;
        tick(); check_all("os_restart", 0, 0, 1, 0);
        tick(); check_all("os_start_in_run", 1, 0, 1, 0);
        start = 1'b0;
        // A load during RUN keeps the FSM in RUN.
        load = 1'b1; load_val = 4'd6;
        tick(); check_all("os_load_run", 6, 0, 1, 0);
        load = 1'b0;
        tick(); check_all("os_after_load", 7, 0, 1, 0);

        // Leaving ONESHOT returns the FSM to IDLE and keeps the count.
        mode = 2'd0; en = 1'b0;
        tick(); check_all("os_leave", 7, 0, 0, 0);
        mode = 2'd2; en = 1'b1;
        tick(); check_all("os_idle_hold", 7, 0, 0, 0);

        // ONESHOT counting down: start gives MOD_MAX, then counts to 5.
        dir = 1'b0; start = 1'b1;
        tick(); check_all("os_dn_start", 9, 0, 1, 0);
        start = 1'b0;
        tick(); tick(); tick(); tick();
        check_all("os_dn_5", 5, 0, 1, 0);

        // Reset during RUN overrides load and start in the same cycle.
        rst_n = 1'b0; load = 1'b1; load_val = 4'd3; start = 1'b1;
        tick(); check_all("rst_mid", 0, 0, 0, 0);
        rst_n = 1'b1; load = 1'b0; start = 1'b0;
        tick(); check_all("rst_idle", 0, 0, 0, 0);

`ifdef PARAM_COUNTER_PRESCALE_EN
        // prescale=2: one step every 3 enabled cycles, with the phase frozen while en is low.
        mode = 2'd0; dir = 1'b1; prescale = 4'd2; load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0;
        tick(); check("ps_c1", 32'(count), 32'd0);
        tick(); check("ps_c2", 32'(count), 32'd0);
        tick(); check("ps_c3", 32'(count), 32'd1);
        tick(); check("ps_c4", 32'(count), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(); check("ps_frozen", 32'(count), 32'd1);
        end
        en = 1'b1;
        tick(); check("ps_resume1", 32'(count), 32'd1);
        tick(); check("ps_resume2", 32'(count), 32'd2);
`else
        // Without the prescaler, the prescale input has no effect.
        mode = 2'd0; dir = 1'b1; prescale = 4'd2; load = 1'b1; load_val = 4'd0;
        tick();
        load = 1'b0;
        tick(); check("nops_1", 32'(count), 32'd1);
        tick(); check("nops_2", 32'(count), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_param_counter
